// File: rtl/d_cache_setassoc_burst.sv
// N-way set-associative write-back/write-allocate data cache with multi-word lines,
// tree pseudo-LRU replacement, and a writeback-then-refill miss engine (one word per memory transaction).
module d_cache_setassoc_burst #(
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4,
  parameter int WAY_WIDTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic        cache_data_req,
  output logic        cache_data_wr,
  output logic [1:0]  cache_data_size,
  output logic [31:0] cache_data_addr,
  output logic [31:0] cache_data_wdata,
  input  logic [31:0] cache_data_rdata,
  input  logic        cache_data_addr_ok,
  input  logic        cache_data_data_ok,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int WW        = OFFSET_WIDTH - 2;
  localparam int WORDS     = 1 << WW;
  localparam int WAY_NUM   = 1 << WAY_WIDTH;
  localparam int SETS      = 1 << INDEX_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_RF   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [31:0]          data_q  [WAY_NUM][SETS][WORDS];
  logic [TAG_WIDTH-1:0] tag_q   [WAY_NUM][SETS];
  logic [WAY_NUM-1:0]   valid_q [SETS];
  logic [WAY_NUM-1:0]   dirty_q [SETS];
  logic [WAY_NUM-2:0]   plru_q  [SETS];

  logic [1:0]           state_q;
  logic [31:0]          addr_q;
  logic                 wr_q;
  logic [1:0]           size_q;
  logic [31:0]          wdata_q;
  logic [WAY_WIDTH-1:0] way_q;
  logic [WW-1:0]        wcnt_q;
  logic                 adone_q;
  logic [31:0]          hit_cnt_q;
  logic [31:0]          miss_cnt_q;

  logic [TAG_WIDTH-1:0]   req_tag, lat_tag;
  logic [INDEX_WIDTH-1:0] req_idx, lat_idx;
  logic [WW-1:0]          req_word, lat_word;
  logic                   hit, inv_found, idle_req, mem_phase, xfer_done, last_word;
  logic [WAY_WIDTH-1:0]   hit_way, inv_way, victim;
  logic [31:0]            hit_word;

  // Heap-ordered tree: node n has children 2n+1 (bit 0) and 2n+2 (bit 1).
  function automatic logic [WAY_WIDTH-1:0] plru_victim(input logic [WAY_NUM-2:0] p);
    logic [WAY_NUM-2:0] s;
    int n;
    n = 0;
    for (int unsigned l = 0; l < WAY_WIDTH; l++) begin
      s = p >> n;
      n = 2 * n + 1 + int'(s[0]);
    end
    return WAY_WIDTH'(n - (WAY_NUM - 1));
  endfunction

  function automatic logic [WAY_NUM-2:0] plru_touch(input logic [WAY_NUM-2:0] p,
                                                    input logic [WAY_WIDTH-1:0] w);
    logic [WAY_NUM-2:0]   one;
    logic [WAY_WIDTH-1:0] ws;
    int n;
    one = (WAY_NUM - 1)'(1);
    n   = 0;
    for (int unsigned l = 0; l < WAY_WIDTH; l++) begin
      ws = w >> (WAY_WIDTH - 1 - l);
      if (ws[0]) p = p & ~(one << n);
      else       p = p | (one << n);
      n = 2 * n + 1 + int'(ws[0]);
    end
    return p;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [1:0] size, input logic [1:0] lo);
    logic [3:0]  be;
    logic [31:0] m;
    case (size)
      2'd0:    be = 4'b0001 << lo;
      2'd1:    be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_w & ~m) | (new_w & m);
  endfunction

  assign req_tag  = cpu_data_addr[31 -: TAG_WIDTH];
  assign req_idx  = cpu_data_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_word = cpu_data_addr[2 +: WW];
  assign lat_tag  = addr_q[31 -: TAG_WIDTH];
  assign lat_idx  = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
  assign lat_word = addr_q[2 +: WW];

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAY_NUM; w++) begin
      if (valid_q[req_idx][WAY_WIDTH'(w)] && (tag_q[WAY_WIDTH'(w)][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_WIDTH'(w);
      end
      if (!valid_q[req_idx][WAY_WIDTH'(w)] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_WIDTH'(w);
      end
    end
    victim = inv_found ? inv_way : plru_victim(plru_q[req_idx]);
  end

  assign hit_word  = data_q[hit_way][req_idx][req_word];
  assign idle_req  = (state_q == S_IDLE) && cpu_data_req;
  assign mem_phase = (state_q == S_WB) || (state_q == S_RF);
  // A data_ok in the same cycle as addr_ok completes the word in one step.
  assign xfer_done = mem_phase && cache_data_data_ok && (adone_q || cache_data_addr_ok);
  assign last_word = (wcnt_q == WW'(WORDS - 1));

  assign cpu_data_addr_ok = idle_req;
  assign cpu_data_data_ok = (idle_req && hit) || (state_q == S_RESP);
  assign cpu_data_rdata   = (idle_req && hit)      ? hit_word :
                            (state_q == S_RESP)    ? data_q[way_q][lat_idx][lat_word] : '0;

  assign cache_data_req   = mem_phase && !adone_q;
  assign cache_data_wr    = (state_q == S_WB);
  assign cache_data_size  = 2'b10;
  assign cache_data_addr  = (state_q == S_WB) ? {tag_q[way_q][lat_idx], lat_idx, wcnt_q, 2'b00} :
                            (state_q == S_RF) ? {lat_tag, lat_idx, wcnt_q, 2'b00} : '0;
  assign cache_data_wdata = (state_q == S_WB) ? data_q[way_q][lat_idx][wcnt_q] : '0;

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      size_q     <= '0;
      wdata_q    <= '0;
      way_q      <= '0;
      wcnt_q     <= '0;
      adone_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[INDEX_WIDTH'(s)] <= '0;
        dirty_q[INDEX_WIDTH'(s)] <= '0;
        plru_q[INDEX_WIDTH'(s)]  <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu_data_req) begin
            if (hit) begin
              hit_cnt_q       <= hit_cnt_q + 32'd1;
              plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
              if (cpu_data_wr) dirty_q[req_idx][hit_way] <= 1'b1;
            end else begin
              miss_cnt_q <= miss_cnt_q + 32'd1;
              addr_q     <= cpu_data_addr;
              wr_q       <= cpu_data_wr;
              size_q     <= cpu_data_size;
              wdata_q    <= cpu_data_wdata;
              way_q      <= victim;
              wcnt_q     <= '0;
              adone_q    <= 1'b0;
              state_q    <= (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) ? S_WB : S_RF;
            end
          end
        end
        S_WB, S_RF: begin
          if (xfer_done) begin
            adone_q <= 1'b0;
            wcnt_q  <= wcnt_q + WW'(1);
            if (last_word) begin
              if (state_q == S_WB) begin
                state_q <= S_RF;
              end else begin
                valid_q[lat_idx][way_q] <= 1'b1;
                dirty_q[lat_idx][way_q] <= wr_q;
                plru_q[lat_idx]         <= plru_touch(plru_q[lat_idx], way_q);
                state_q                 <= S_RESP;
              end
            end
          end else if (cache_data_req && cache_data_addr_ok) begin
            adone_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Line storage needs no reset; the valid bits gate every read of it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (idle_req && hit && cpu_data_wr)
        data_q[hit_way][req_idx][req_word] <=
          merge_store(hit_word, cpu_data_wdata, cpu_data_size, cpu_data_addr[1:0]);
      if ((state_q == S_RF) && xfer_done) begin
        // A pending store is merged as its word arrives, so RESP already sees the final word.
        data_q[way_q][lat_idx][wcnt_q] <= (wr_q && (wcnt_q == lat_word)) ?
          merge_store(cache_data_rdata, wdata_q, size_q, addr_q[1:0]) : cache_data_rdata;
        if (last_word) tag_q[way_q][lat_idx] <= lat_tag;
      end
    end
  end

endmodule

// File: doc/d_cache_setassoc_burst.md
Name: d_cache_setassoc_burst

Overview:
Parametrised N-way set-associative, write-back, write-allocate data cache with multi-word lines, placed between the MIPS core data port and the AXI bridge. Both sides use the sram-like req/addr_ok/data_ok protocol. Victim selection uses a generalised tree pseudo-LRU. Miss handling is done by a writeback-then-refill FSM that moves one word per memory transaction. Hit and miss counters are included for performance measurement.

Parameters:
INDEX_WIDTH, 6, set index bits; sets = 2^INDEX_WIDTH
OFFSET_WIDTH, 4, byte offset bits; words per line WORDS = 2^(OFFSET_WIDTH-2); must be >= 2
WAY_WIDTH, 2, log2 of ways; WAY_NUM = 2^WAY_WIDTH; must be >= 1
TAG_WIDTH (local), 32-INDEX_WIDTH-OFFSET_WIDTH

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cpu_data_req  in  1  core request valid
cpu_data_wr  in  1  1 = store
cpu_data_size  in  2  0 = byte, 1 = half, 2 = word
cpu_data_addr  in  32  byte address
cpu_data_wdata  in  32  store data, byte lanes aligned to addr[1:0]
cpu_data_rdata  out  32  load word
cpu_data_addr_ok  out  1  request accepted
cpu_data_data_ok  out  1  request complete
cache_data_req  out  1  memory request
cache_data_wr  out  1  1 = writeback word
cache_data_size  out  2  always 2'b10
cache_data_addr  out  32  word-aligned memory address
cache_data_wdata  out  32  writeback data
cache_data_rdata  in  32  refill data
cache_data_addr_ok  in  1  memory address handshake
cache_data_data_ok  in  1  memory data handshake
hit_cnt  out  32  accepted requests that hit, wraps at 2^32
miss_cnt  out  32  accepted requests that missed, wraps at 2^32

Behaviour:
- Reset (synchronous, active-high) applies in any state, including mid-burst. Effects: state = IDLE; all valid, dirty and PLRU bits = 0; counters = 0. All outputs = 0 except cache_data_size = 2'b10. Any pending memory transaction is abandoned.
- Address split: tag = addr[31:INDEX_WIDTH+OFFSET_WIDTH]; index = next INDEX_WIDTH bits; word = addr[OFFSET_WIDTH-1:2].
- FSM states: IDLE, WB, RF, RESP. Only one core request is outstanding at a time.
- IDLE, hit:
  - addr_ok and data_ok are asserted combinationally in the request cycle. Latency is 0.
  - Load: rdata = the addressed word.
  - Store: merge bytes using the size/addr[1:0] mask (byte: one lane; half: addr[1] ? 1100 : 0011; word: 1111), then set dirty.
  - Update PLRU for the hit way; hit_cnt += 1.
- IDLE, miss:
  - addr_ok = 1 and data_ok = 0 in that cycle.
  - Latch addr, wr, size, wdata and the chosen victim way; miss_cnt += 1.
  - Next state: WB if the victim is valid and dirty, else RF.
- Victim selection: the lowest-numbered invalid way; if all ways are valid, the PLRU victim.
- PLRU: WAY_NUM-1 node bits per set, heap-ordered with root = node 0.
  - Victim walk: at each node, 0 selects the left subtree, 1 selects the right.
  - On access to way w, every node on w's path is set to point away from w.
  - Updated on each hit and on each miss completion (for the filled way).
- WB: WORDS single-word write transactions, words 0 to WORDS-1.
  - Address = {victim_tag, index, wcnt, 2'b00}; wdata = victim word wcnt.
  - cache_data_req is held high until addr_ok, then low until data_ok; wcnt then increments.
  - After the last data_ok: go to RF, wcnt = 0.
- RF: WORDS read transactions with the same handshake.
  - Address = {tag, index, wcnt, 2'b00}; each data_ok writes cache_data_rdata into word wcnt of the victim way.
  - After the last word: valid = 1, tag written, dirty = 0. A latched store is merged into the line with dirty = 1. Go to RESP.
- RESP: one cycle.
  - data_ok = 1; rdata = the requested word of the refilled line (after merge for stores).
  - addr_ok = 0 (no new request is accepted in this cycle); next state is IDLE.
- Outside IDLE hit/miss cycles: addr_ok = 0. data_ok is 1 only in RESP.
- Memory data_ok and addr_ok arriving in the same cycle count as both handshakes complete.
- cache_data_req is never asserted in IDLE or RESP.

Test Plan:
- Cold load 0x0000_0040 with memory words at 0x40..0x4C = 1,2,3,4 → 4 refill reads at 0x40, 0x44, 0x48, 0x4C; RESP rdata = 1; miss_cnt = 1. A following load of 0x48 hits in 0 cycles with rdata = 3; hit_cnt = 1.
- Store byte 0xAB to 0x41 after the line is resident with word 0x11223344 → the next load of 0x40 returns 0x1122AB44; the line is dirty; no memory traffic.
- Fill 4 ways of set 4 (tags 0..3), access ways in order 0,1,2,3, then load a 5th tag → the victim is way 0 per PLRU. If way 0 is dirty, 4 writebacks to {tag0, 4, w, 00} occur before the 4 refill reads.
- Store miss to a clean victim → refill, merge, RESP data_ok; the line is valid and dirty and holds the merged word.
- Assert rst during the 2nd WB word → next cycle all outputs = 0 (size = 2'b10); a reload of the same address misses; counters = 0.
- Memory delays addr_ok by 3 cycles and data_ok by 5 cycles → cache_data_req is held steady with a stable address; exactly WORDS transactions occur; no duplicate requests.
